// File: rtl/komandara_k10_pkg.sv
// Shared types for the K10 writeback path: hold-entry FSM states and writeback request.
package komandara_k10_pkg;

  localparam int K10_NUM_REGS = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/k10_wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module k10_wb_scoreboard
  import komandara_k10_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       set,
  input  logic [4:0] set_rd,
  input  logic       clr,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic       rs1_busy,
  output logic       rs2_busy
);

  logic [K10_NUM_REGS-1:0] pending_reg;
  logic [K10_NUM_REGS-1:0] pending_next;

  // A set wins over a clear of the same register so a re-issued op stays tracked.
  generate
    for (genvar gi = 0; gi < K10_NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit          = set && (set_rd == 5'(gi));
        assign clr_hit          = clr && (clr_rd == 5'(gi));
        assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign rs1_busy = pending_reg[rs1_addr];
  assign rs2_busy = pending_reg[rs2_addr];

endmodule

// File: rtl/k10_wb_arbiter.sv
// Writeback arbiter: EX first, then a one-deep hold entry, then long-latency results.
// Optional deferred-cycle counter enabled by defining K10_WB_DEFER_CNT_EN.
module k10_wb_arbiter
  import komandara_k10_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_data,
  input  logic        i_lu_valid,
  input  logic [4:0]  i_lu_rd,
  input  logic [31:0] i_lu_data,
  output logic        o_lu_ready,
  input  logic        i_sb_set,
  input  logic [4:0]  i_sb_rd,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_wr_en,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_defer_cnt
);

  wb_state_e   state_reg;
  wb_state_e   state_next;
  wb_req_t     hold_reg;
  wb_req_t     sel_req;
  logic        sel_valid;
  logic        sel_ll;
  logic        hold_capture;
  logic        lu_acc;
  logic        wr_en_reg;
  logic [4:0]  rd_addr_reg;
  logic [31:0] rd_data_reg;

  assign o_lu_ready = (state_reg == EMPTY) && !i_rst;
  assign lu_acc     = i_lu_valid && o_lu_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (lu_acc && i_ex_valid) state_next = HELD;
      HELD:    if (!i_ex_valid) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    sel_valid    = 1'b0;
    sel_ll       = 1'b0;
    sel_req      = '0;
    hold_capture = 1'b0;
    if (i_ex_valid) begin
      sel_valid    = 1'b1;
      sel_req      = '{rd: i_ex_rd, data: i_ex_data};
      hold_capture = lu_acc;
    end else if (state_reg == HELD) begin
      sel_valid = 1'b1;
      sel_ll    = 1'b1;
      sel_req   = hold_reg;
    end else if (lu_acc) begin
      sel_valid = 1'b1;
      sel_ll    = 1'b1;
      sel_req   = '{rd: i_lu_rd, data: i_lu_data};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_reg <= '0;
    end else if (hold_capture) begin
      hold_reg <= '{rd: i_lu_rd, data: i_lu_data};
    end
  end

  // Writes to x0 still load address/data; only the enable is suppressed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_en_reg <= sel_valid && (sel_req.rd != 5'd0);
      if (sel_valid) begin
        rd_addr_reg <= sel_req.rd;
        rd_data_reg <= sel_req.data;
      end
    end
  end

  assign o_wr_en   = wr_en_reg;
  assign o_rd_addr = rd_addr_reg;
  assign o_rd_data = rd_data_reg;

  k10_wb_scoreboard u_scoreboard (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .set      (i_sb_set),
    .set_rd   (i_sb_rd),
    .clr      (sel_valid && sel_ll),
    .clr_rd   (sel_req.rd),
    .rs1_addr (i_rs1_addr),
    .rs2_addr (i_rs2_addr),
    .rs1_busy (o_rs1_busy),
    .rs2_busy (o_rs2_busy)
  );

`ifdef K10_WB_DEFER_CNT_EN
  logic [31:0] defer_cnt_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      defer_cnt_reg <= '0;
    end else if ((state_reg == HELD) && (defer_cnt_reg != 32'hFFFF_FFFF)) begin
      defer_cnt_reg <= defer_cnt_reg + 32'd1;
    end
  end

  assign o_defer_cnt = defer_cnt_reg;
`else
  assign o_defer_cnt = '0;
`endif

endmodule

// File: doc/k10_wb_arbiter.md
K10_WB_ARBITER -- requirements
Module: k10_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows (clock and reset first).
- i_clk  in  1  core clock; all state changes on its rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_ex_valid  in  1  EX result valid; EX has no backpressure.
- i_ex_rd  in  5  EX destination register.
- i_ex_data  in  32  EX result.
- i_lu_valid  in  1  long-latency unit (LSU/MDU) result valid.
- i_lu_rd  in  5  long-latency destination register.
- i_lu_data  in  32  long-latency result.
- o_lu_ready  out  1  long-latency result accepted when high with i_lu_valid.
- i_sb_set  in  1  long-latency op issued this cycle.
- i_sb_rd  in  5  destination of the issued long-latency op.
- i_rs1_addr  in  5  issue-stage source 1.
- i_rs2_addr  in  5  issue-stage source 2.
- o_rs1_busy  out  1  source 1 has a pending long-latency write.
- o_rs2_busy  out  1  source 2 has a pending long-latency write.
- o_wr_en  out  1  register-file write enable.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data.
- o_defer_cnt  out  32  deferred-cycle counter (see Configuration).

Function
REQ-002 The register-file write outputs SHALL be registered, so a result appears on o_wr_en/o_rd_addr/o_rd_data exactly 1 cycle after it is selected.
REQ-003 Each cycle, exactly one source SHALL be selected, by priority: EX (i_ex_valid), then the hold entry, then an accepted long-latency result.
REQ-004 A long-latency result SHALL be accepted when i_lu_valid && o_lu_ready.
REQ-005 o_lu_ready SHALL equal (state == EMPTY) && !i_rst.
REQ-006 The hold entry SHALL be controlled by a 2-state FSM with states EMPTY and HELD.
- EMPTY->HELD: an accepted long-latency result coincides with i_ex_valid; the result is captured into the hold entry.
- HELD->EMPTY: the first cycle with !i_ex_valid; the held result is selected.
- HELD with i_ex_valid: stay HELD; EX is selected.
REQ-007 A selected write with rd == 0 SHALL produce o_wr_en = 0; the source is still consumed and the FSM still advances.
REQ-008 When no source is selected, o_wr_en SHALL be 0 and o_rd_addr/o_rd_data SHALL hold their previous values.
REQ-009 The scoreboard SHALL be a 32-bit pending vector whose bit 0 is constant 0.
REQ-010 On i_sb_set with i_sb_rd != 0, pending[i_sb_rd] SHALL be set at the next edge.
REQ-011 Pending[rd] SHALL be cleared at the edge on which a long-latency result (direct or held) is loaded into the output register.
REQ-012 A set and a clear of the same register in the same cycle SHALL leave the bit set.
REQ-013 EX writes SHALL NOT modify the pending vector.
REQ-014 o_rs1_busy SHALL equal pending[i_rs1_addr], and o_rs2_busy SHALL equal pending[i_rs2_addr], combinationally with no bypass of same-cycle set/clear.
REQ-015 The block SHALL accept a long-latency result in every cycle without EX traffic (full throughput); no result SHALL be dropped or duplicated.

Reset
REQ-016 While i_rst is high, the block SHALL hold: state = EMPTY, pending = 0, o_wr_en = 0, o_rd_addr = 0, o_rd_data = 0, o_defer_cnt = 0, o_lu_ready = 0.
REQ-017 A reset asserted while HELD SHALL discard the held result, with no write issued.
REQ-018 After i_rst falls, o_lu_ready SHALL be 1 in the first cycle.

Configuration
REQ-019 With K10_WB_DEFER_CNT_EN defined, o_defer_cnt SHALL increment by 1 on every cycle with state == HELD, saturating at 32'hFFFF_FFFF.
REQ-020 Without K10_WB_DEFER_CNT_EN, the o_defer_cnt port SHALL still exist, SHALL be tied to 0, and no counter flops SHALL be generated.

Structure
REQ-021 The shared package komandara_k10_pkg SHALL hold wb_state_e (EMPTY, HELD), the struct wb_req_t {rd[4:0], data[31:0]} and K10_NUM_REGS = 32.
REQ-022 The scoreboard SHALL be a sub-module, k10_wb_scoreboard, with ports set, set_rd, clr, clr_rd, rs1/rs2 addresses and busy outputs.

Verification
REQ-023 The bench SHALL cover these directed scenarios.
- EX only: i_ex_valid with rd=5, data=0xDEAD_BEEF -> next cycle o_wr_en=1, o_rd_addr=5, o_rd_data=0xDEAD_BEEF.
- Collision: EX (rd=3, 0x11) and LU (rd=7, 0x22) in the same cycle, then idle -> writes rd3=0x11, then rd7=0x22 on consecutive cycles; o_lu_ready=0 for 1 cycle; o_defer_cnt=1 (macro on).
- Scoreboard: i_sb_set rd=9, then i_rs1_addr=9 -> o_rs1_busy=1 until the cycle after the LU rd=9 write loads, then 0.
- Set/clear same register: pending[4]=1; LU rd=4 write loads and i_sb_set rd=4 in the same cycle -> bit stays 1.
- x0: LU rd=0 with data 0xFFFF_FFFF -> o_wr_en stays 0, o_lu_ready=1; i_sb_set rd=0 -> o_rs1_busy=0 for i_rs1_addr=0.
- Reset in HELD: collision as above, then i_rst pulsed -> no rd7 write, pending=0, o_defer_cnt=0, o_lu_ready=1 the cycle after release.
